// File: rtl/instr_issue_scheduler_pkg.sv
// sched_pkg: opcodes, instruction layout and FSM states shared by the issue scheduler.
package sched_pkg;
  localparam logic [4:0] OP_NONE      = 5'b00000;
  localparam logic [4:0] OP_MAC       = 5'b00001;
  localparam logic [4:0] OP_SEND_WT   = 5'b00010;
  localparam logic [4:0] OP_STORE_OUT = 5'b00011;
  localparam logic [4:0] OP_RECV_INP  = 5'b00100;
  localparam logic [4:0] OP_RECV_WT   = 5'b00101;
  localparam logic [4:0] OP_TX_OUT    = 5'b00110;
  localparam logic [4:0] OP_ACC_RST   = 5'b00111;
  localparam logic [4:0] OP_NOP       = 5'b11111;
  localparam logic [63:0] NOP_WORD = 64'h1F;
  typedef struct packed {
    logic [10:0] rsvd;
    logic [31:0] data;
    logic [15:0] addr;
    logic [4:0]  op;
  } instr_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  function automatic logic is_stream(input logic [4:0] op);
    return op == OP_MAC || op == OP_SEND_WT;
  endfunction
endpackage

// File: rtl/instr_issue_scheduler_if.sv
// instr_issue_scheduler_if: host push channel and issue-side status of the scheduler.
interface instr_issue_scheduler_if #(parameter int FIFO_DEPTH = 8);
  logic [63:0] host_instr;
  logic host_valid;
  logic host_ready;
  logic [63:0] issue_instr;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [15:0] issued_cnt;
  modport master(output host_instr, host_valid, input host_ready, issue_instr, busy, fifo_count, issued_cnt);
  modport slave(input host_instr, host_valid, output host_ready, issue_instr, busy, fifo_count, issued_cnt);
endinterface

// File: rtl/instr_issue_scheduler_fifo.sv
// instr_fifo: synchronous FIFO with occupancy count; writes when full and reads when empty are ignored.
module instr_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [W-1:0] din,
  input  logic rd_en,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    push = wr_en && !full;
    pop = rd_en && !empty;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end
  assign dout = mem[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/instr_issue_scheduler.sv
// instr_issue_scheduler: buffers host instructions and issues one per cycle,
// padding MAC / send-weights streams (and MAC accumulator drain) with NOP words.
module instr_issue_scheduler
  import sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int STREAM_LEN = 16,
  parameter int DRAIN_LEN = 4
) (
  input logic clk,
  input logic rst,
  instr_issue_scheduler_if.slave bus
);
  localparam int CMAX = STREAM_LEN > DRAIN_LEN ? STREAM_LEN : DRAIN_LEN;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  logic full, empty, push, pop;
  logic [63:0] fifo_dout;
  instr_t head;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mac_q, mac_d;
  logic [63:0] issue_q, issue_d;
  logic [15:0] issued_q, issued_d;
  assign head = instr_t'(fifo_dout);
  assign bus.host_ready = !full && !rst;
  assign push = bus.host_valid && bus.host_ready && bus.host_instr[4:0] != OP_NONE;
  instr_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .din(bus.host_instr),
    .rd_en(pop),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(bus.fifo_count)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mac_d = mac_q;
    issue_d = NOP_WORD;
    issued_d = issued_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !empty;
        issue_d = empty ? '0 : fifo_dout;
        issued_d = issued_q + 16'(pop);
        if (pop && is_stream(head.op)) begin
          state_d = STREAM;
          cnt_d = CW'(STREAM_LEN - 1);
          mac_d = head.op == OP_MAC;
        end
      end
      STREAM: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = mac_q ? DRAIN : IDLE;
          cnt_d = CW'(DRAIN_LEN - 1);
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mac_q <= 1'b0;
      issue_q <= '0;
      issued_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mac_q <= mac_d;
      issue_q <= issue_d;
      issued_q <= issued_d;
    end
  end
  assign bus.issue_instr = issue_q;
  assign bus.busy = state_q != IDLE;
  assign bus.issued_cnt = issued_q;
endmodule

// File: tb/tb_instr_issue_scheduler.sv
// tb_instr_issue_scheduler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_instr_issue_scheduler;
  import sched_pkg::*;
  localparam int DEPTH = 8;
  localparam int SL = 16;
  localparam int DL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  instr_issue_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus();
  instr_issue_scheduler #(.FIFO_DEPTH(DEPTH), .STREAM_LEN(SL), .DRAIN_LEN(DL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] mq[$];
  int m_gap = 0;
  logic [63:0] m_issue = '0;
  logic [15:0] m_issued = '0;
  logic rdy_obs, rdy_exp;
  logic [63:0] seen[$];
  function automatic logic [63:0] mk(input logic [4:0] op);
    return {11'h0, $urandom(), 16'($urandom()), op};
  endfunction
  // Model: after a MAC the next real issue waits SL+DL cycles, after send-weights SL cycles.
  task automatic model_edge(input logic v, input logic [63:0] w);
    bit rdy;
    logic [4:0] op;
    rdy = mq.size() < DEPTH;
    if (m_gap > 0) begin
      m_gap--;
      m_issue = NOP_WORD;
    end else if (mq.size() > 0) begin
      m_issue = mq.pop_front();
      m_issued++;
      op = m_issue[4:0];
      m_gap = op == OP_MAC ? SL + DL : op == OP_SEND_WT ? SL : 0;
    end else m_issue = '0;
    op = w[4:0];
    if (v && rdy && op != OP_NONE) mq.push_back(w);
  endtask
  task automatic cyc(input logic v, input logic [63:0] w);
    bus.host_valid = v;
    bus.host_instr = w;
    #1;
    rdy_obs = bus.host_ready;
    rdy_exp = !rst && mq.size() < DEPTH;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_gap = 0;
      m_issue = '0;
      m_issued = '0;
    end else model_edge(v, w);
    @(negedge clk);
    seen.push_back(bus.issue_instr);
  endtask
  task automatic settle();
    repeat (SL + DL + 4) cyc(1'b0, '0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      cyc(1'b1, mk(OP_RECV_INP));
      vectors++;
      if (rdy_obs !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", rdy_obs); end
    end
    vectors += 4;
    if (bus.issue_instr !== 64'h0) begin miscompares++; $display("FAIL reset_issue got=%h want=0", bus.issue_instr); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got=%0d want=0", bus.fifo_count); end
    if (bus.issued_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_issued got=%0d want=0", bus.issued_cnt); end
    rst = 1'b0;
  endtask
  task automatic test_latency();
    logic [63:0] w;
    w = 64'h0000_0000_0000_0084;
    cyc(1'b1, w);
    vectors += 2;
    if (bus.issue_instr !== 64'h0) begin miscompares++; $display("FAIL lat_t1 got=%h want=0", bus.issue_instr); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy1 got=%b want=0", bus.busy); end
    cyc(1'b0, '0);
    vectors += 3;
    if (bus.issue_instr !== w) begin miscompares++; $display("FAIL lat_t2 got=%h want=%h", bus.issue_instr, w); end
    if (bus.issued_cnt !== 16'd1) begin miscompares++; $display("FAIL lat_issued got=%0d want=1", bus.issued_cnt); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy2 got=%b want=0", bus.busy); end
  endtask
  task automatic test_stream(input logic [4:0] op, input logic [4:0] next_op, input int gap);
    logic [63:0] s, n;
    settle();
    s = mk(op);
    n = mk(next_op);
    cyc(1'b1, s);
    cyc(1'b1, n);
    vectors += 2;
    if (bus.issue_instr !== s) begin miscompares++; $display("FAIL stream_head op=%0d got=%h want=%h", op, bus.issue_instr, s); end
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL stream_busy0 op=%0d got=%b want=1", op, bus.busy); end
    for (int k = 1; k <= gap; k++) begin
      cyc(1'b0, '0);
      vectors += 2;
      if (bus.issue_instr !== NOP_WORD) begin miscompares++; $display("FAIL stream_nop op=%0d k=%0d got=%h want=%h", op, k, bus.issue_instr, NOP_WORD); end
      if (bus.busy !== (k < gap)) begin miscompares++; $display("FAIL stream_busy op=%0d k=%0d got=%b want=%b", op, k, bus.busy, k < gap); end
    end
    cyc(1'b0, '0);
    vectors += 2;
    if (bus.issue_instr !== n) begin miscompares++; $display("FAIL stream_next op=%0d got=%h want=%h", op, bus.issue_instr, n); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL stream_idle op=%0d got=%b want=0", op, bus.busy); end
  endtask
  task automatic test_full();
    logic [63:0] mac, ws[9], exp_q[$], got[$];
    int waited;
    bit accepted;
    settle();
    mac = mk(OP_MAC);
    cyc(1'b1, mac);
    cyc(1'b0, '0);
    exp_q.push_back(mac);
    for (int i = 0; i < 9; i++) begin
      ws[i] = mk(5'(3 + $urandom_range(0, 4)));
      exp_q.push_back(ws[i]);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, ws[i]);
      vectors++;
      if (rdy_obs !== 1'b1) begin miscompares++; $display("FAIL full_ready i=%0d got=%b want=1", i, rdy_obs); end
    end
    vectors++;
    if (bus.fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_count got=%0d want=8", bus.fifo_count); end
    waited = 0;
    accepted = 0;
    while (!accepted && waited < 40) begin
      cyc(1'b1, ws[8]);
      if (rdy_obs) accepted = 1;
      else waited++;
    end
    vectors += 2;
    if (!accepted) begin miscompares++; $display("FAIL full_accept got=0 want=1"); end
    if (waited != 13) begin miscompares++; $display("FAIL full_held cycles got=%0d want=13", waited); end
    repeat (20) cyc(1'b0, '0);
    foreach (seen[i]) if (seen[i] !== 64'h0 && seen[i] !== NOP_WORD) got.push_back(seen[i]);
    vectors++;
    if (got.size() < exp_q.size()) begin miscompares++; $display("FAIL full_nwords got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[got.size() - exp_q.size() + i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL full_order i=%0d got=%h want=%h", i, got[got.size() - exp_q.size() + i], exp_q[i]);
      end
    end
  endtask
  task automatic test_filter();
    logic [63:0] a, z, b;
    logic [15:0] base;
    int ia;
    settle();
    base = m_issued;
    a = mk(OP_ACC_RST);
    z = mk(OP_NONE);
    b = mk(OP_ACC_RST);
    cyc(1'b1, mk(OP_MAC));
    cyc(1'b0, '0);
    seen.delete();
    cyc(1'b1, a);
    cyc(1'b1, z);
    cyc(1'b1, b);
    vectors++;
    if (bus.fifo_count !== 4'd2) begin miscompares++; $display("FAIL filt_count got=%0d want=2", bus.fifo_count); end
    repeat (25) cyc(1'b0, '0);
    ia = -1;
    foreach (seen[i]) if (seen[i] === a && ia < 0) ia = i;
    vectors += 3;
    if (ia < 0) begin miscompares++; $display("FAIL filt_first got=absent want=%h", a); end
    else if (ia + 1 >= seen.size() || seen[ia + 1] !== b) begin
      miscompares++;
      $display("FAIL filt_consec got=%h want=%h", ia + 1 < seen.size() ? seen[ia + 1] : 64'hx, b);
    end
    if (bus.issued_cnt !== base + 16'd3) begin miscompares++; $display("FAIL filt_issued got=%0d want=%0d", bus.issued_cnt, base + 16'd3); end
    if (z inside {seen}) begin miscompares++; $display("FAIL filt_leak got=%h want=absent", z); end
  endtask
  task automatic test_reset_mid();
    logic [63:0] w[3];
    settle();
    cyc(1'b1, mk(OP_MAC));
    cyc(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      w[i] = mk(OP_STORE_OUT);
      cyc(1'b1, w[i]);
    end
    cyc(1'b0, '0);
    rst = 1'b1;
    cyc(1'b0, '0);
    rst = 1'b0;
    vectors += 5;
    if (rdy_obs !== 1'b0) begin miscompares++; $display("FAIL rmid_ready got=%b want=0", rdy_obs); end
    if (bus.issue_instr !== 64'h0) begin miscompares++; $display("FAIL rmid_issue got=%h want=0", bus.issue_instr); end
    if (bus.fifo_count !== 4'd0) begin miscompares++; $display("FAIL rmid_count got=%0d want=0", bus.fifo_count); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    if (bus.issued_cnt !== 16'd0) begin miscompares++; $display("FAIL rmid_issued got=%0d want=0", bus.issued_cnt); end
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, '0);
      vectors++;
      if (bus.issue_instr !== 64'h0) begin miscompares++; $display("FAIL rmid_quiet k=%0d got=%h want=0", k, bus.issue_instr); end
    end
  endtask
  task automatic test_random();
    logic [4:0] ops[10];
    ops = '{OP_NONE, OP_MAC, OP_SEND_WT, OP_STORE_OUT, OP_RECV_INP, OP_RECV_WT, OP_TX_OUT, OP_ACC_RST, OP_NOP, 5'b01010};
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 149) == 0;
      cyc($urandom_range(0, 1) == 1, mk(ops[$urandom_range(0, 9)]));
      vectors += 5;
      if (rdy_obs !== rdy_exp) begin miscompares++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, rdy_obs, rdy_exp); end
      if (bus.issue_instr !== m_issue) begin miscompares++; $display("FAIL rnd_issue n=%0d got=%h want=%h", n, bus.issue_instr, m_issue); end
      if (bus.busy !== (m_gap > 0)) begin miscompares++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, bus.busy, m_gap > 0); end
      if (bus.fifo_count !== 4'(mq.size())) begin miscompares++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.fifo_count, mq.size()); end
      if (bus.issued_cnt !== m_issued) begin miscompares++; $display("FAIL rnd_issued n=%0d got=%0d want=%0d", n, bus.issued_cnt, m_issued); end
    end
    rst = 1'b0;
  endtask
  initial begin
    bus.host_valid = 1'b0;
    bus.host_instr = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_stream(OP_MAC, OP_STORE_OUT, SL + DL);
    test_stream(OP_SEND_WT, OP_RECV_WT, SL);
    test_full();
    test_filter();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_issue_scheduler.md
Name: instr_issue_scheduler

Overview:
Sits between the host instruction source and the instruction decoder (controller) of the systolic array. Buffers incoming 64-bit instructions in a small FIFO and issues them one per cycle. After any streaming instruction (MAC or Send weights) it holds issue for a fixed window and fills the gap with NOP words, so buffer writes, stores and accumulator resets never overlap an in-flight stream.

Parameters:
FIFO_DEPTH, 8, instruction FIFO entries; power of 2, >=2.
STREAM_LEN, 16, cycles a MAC or Send-weights stream occupies the array; >=1.
DRAIN_LEN, 4, extra cycles after a MAC stream before the next issue (accumulator settle); >=1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
host_instr  input  64  instruction word; opcode [4:0], address [20:5], data [52:21]
host_valid  input  1  host_instr valid this cycle
host_ready  output  1  FIFO can accept (combinational: !full && !rst)
issue_instr  output  64  registered instruction to the controller
busy  output  1  FSM not in IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
issued_cnt  output  16  count of real (non-filler) instructions issued; wraps at 2^16

Behaviour:
- Reset (rst=1 at an edge), including mid-stream:
  - FIFO flushed; FSM to IDLE; counters to 0.
  - issue_instr=64'h0, busy=0, fifo_count=0, issued_cnt=0.
  - host_ready=0 while rst is high.
- Push:
  - Occurs when host_valid && host_ready.
  - Words with opcode 5'b00000 are filtered: handshake completes but the word is not stored.
  - When full, host_ready=0 and no push occurs.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, STREAM, DRAIN. The counter is $clog2(max(STREAM_LEN,DRAIN_LEN)) bits.
- IDLE, FIFO empty: next issue_instr=64'h0 (no instruction).
- IDLE, FIFO non-empty:
  - Pop head; next issue_instr=head, unmodified; issued_cnt+1.
  - Head opcode 5'b00001 (MAC) or 5'b00010 (Send weights): go to STREAM, cnt=STREAM_LEN-1, and record whether it was MAC.
  - Any other opcode (including 5'b11111 and unknown 01000-11110): stay in IDLE, so back-to-back issue is one per cycle.
- STREAM:
  - Next issue_instr=NOP word (64'h1F: opcode 11111, all other bits 0); no pop.
  - cnt decrements each cycle.
  - At cnt==0: if the recorded stream was MAC, go to DRAIN with cnt=DRAIN_LEN-1; otherwise go to IDLE.
- DRAIN: next issue_instr=NOP word; cnt decrements; at cnt==0 go to IDLE.
- Latency:
  - A word pushed in cycle t into an empty FIFO with FSM in IDLE is visible on issue_instr in cycle t+2.
  - A MAC visible at cycle T: NOPs at T+1..T+STREAM_LEN+DRAIN_LEN; next instruction earliest at T+STREAM_LEN+DRAIN_LEN+1.
  - A Send-weights visible at T: next instruction earliest at T+STREAM_LEN+1.
- Pushes continue during STREAM/DRAIN until the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_count reflects the registered state after each edge.

Decomposition:
- Shared package sched_pkg:
  - opcode localparams OP_NONE=00000, OP_MAC=00001, OP_SEND_WT=00010, OP_STORE_OUT=00011, OP_RECV_INP=00100, OP_RECV_WT=00101, OP_TX_OUT=00110, OP_ACC_RST=00111, OP_NOP=11111.
  - NOP_WORD=64'h1F.
  - instruction field bit ranges.
  - FSM state enum.
- One sub-module: instr_fifo, a synchronous FIFO parameterised by width and depth, with count/full/empty outputs.

Test Plan:
- Reset, then push RECV_INP (64'h…_0084) at cycle 0 -> same word on issue_instr at cycle 2; issued_cnt=1; busy stays 0.
- Push MAC followed by STORE_OUT with defaults -> MAC at T, 64'h1F for cycles T+1..T+20, STORE_OUT at T+21; busy high T..T+19.
- Push SEND_WT followed by RECV_WT -> RECV_WT at T+17; no DRAIN cycles.
- Hold the FIFO during a MAC stream and push 9 words -> host_ready drops after the 8th; 9th held until the first pop; no word lost or reordered.
- Push opcode 00000 between two ACC_RST words -> issue shows ACC_RST on consecutive cycles; issued_cnt+2.
- Assert rst at T+5 of a MAC stream with 3 words queued -> next cycle issue_instr=0, fifo_count=0, busy=0; no queued word is ever issued.
